// File: rtl/rob_pkg.sv
// Shared ROB definitions: index width and the completion record carried through the arbiter.
package rob_pkg;

    localparam int unsigned ROB_IDX_W   = 6;
    localparam int unsigned ROB_ENTRIES = 64;
    localparam int unsigned COMPL_W     = ROB_IDX_W + 33;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] pos;
        logic                 altpc_valid;
        logic [31:0]          altpc;
    } compl_t;

endpackage

// File: rtl/rob_completion_arbiter_if.sv
// Requester-side completion bus plus the shared ROB completion port.
interface rob_completion_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IW = rob_pkg::ROB_IDX_W;

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*IW-1:0] req_pos;
    logic [NUM_REQ-1:0]    req_altpc_valid;
    logic [NUM_REQ*32-1:0] req_altpc;
    logic [NUM_REQ-1:0]    req_ready;

    logic                  newExecuted;
    logic [IW-1:0]         executedPosition;
    logic                  Request_Alt_PC_OUT;
    logic [IW-1:0]         Alt_PC_position;
    logic [31:0]           Alt_PC_OUT;
    logic                  arb_busy;

    // Execute units / ROB side
    modport master (
        output req_valid, req_pos, req_altpc_valid, req_altpc,
        input  req_ready, newExecuted, executedPosition, Request_Alt_PC_OUT,
               Alt_PC_position, Alt_PC_OUT, arb_busy
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_pos, req_altpc_valid, req_altpc,
        output req_ready, newExecuted, executedPosition, Request_Alt_PC_OUT,
               Alt_PC_position, Alt_PC_OUT, arb_busy
    );

endinterface

// File: rtl/completion_fifo.sv
// Per-requester completion FIFO; flush clears occupancy and wins over push/pop.
module completion_fifo
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   CLK,
    input  logic   RESET,
    input  logic   flush_i,
    input  logic   push_i,
    input  compl_t data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output compl_t head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    compl_t           mem_q [DEPTH];
    compl_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Explicit wrap keeps DEPTH=1 (single-slot) correct as well
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Next-state: storage write, pointer advance and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy gates its visibility
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rob_completion_arbiter.sv
// Round-robin sharing of the ROB completion port among NUM_REQ execute units.
module rob_completion_arbiter
    import rob_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FLUSH_IN,
    rob_completion_arbiter_if.slave  bus
);

    localparam int unsigned RR_W = $clog2(NUM_REQ);

    compl_t              push_data [NUM_REQ];
    compl_t              head      [NUM_REQ];
    logic [NUM_REQ-1:0]  full, empty, push, pop;
    logic                found;
    logic [RR_W-1:0]     grant;
    compl_t              sel;

    logic                 new_exec_q, new_exec_d;
    logic [ROB_IDX_W-1:0] exec_pos_q, exec_pos_d;
    logic                 alt_req_q, alt_req_d;
    logic [ROB_IDX_W-1:0] alt_pos_q, alt_pos_d;
    logic [31:0]          alt_pc_q, alt_pc_d;
    logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;

    // Ready is deliberately not pop-aware: a full FIFO refuses even while being drained
    assign bus.req_ready = ~full & {NUM_REQ{!FLUSH_IN && !RESET}};
    assign push          = bus.req_valid & bus.req_ready;
    assign bus.arb_busy  = !RESET && (|(~empty));

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
        assign push_data[gi] = '{
            pos:         bus.req_pos[gi*ROB_IDX_W +: ROB_IDX_W],
            altpc_valid: bus.req_altpc_valid[gi],
            altpc:       bus.req_altpc[gi*32 +: 32]
        };

        completion_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .CLK     (CLK),
            .RESET   (RESET),
            .flush_i (FLUSH_IN),
            .push_i  (push[gi]),
            .data_i  (push_data[gi]),
            .pop_i   (pop[gi]),
            .full_o  (full[gi]),
            .empty_o (empty[gi]),
            .head_o  (head[gi])
        );
    end

    // Find first non-empty FIFO starting at rr_ptr, wrapping at NUM_REQ
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && !empty[RR_W'(idx)]) begin
                found = 1'b1;
                grant = RR_W'(idx);
            end
        end
        pop = '0;
        pop[grant] = found && !FLUSH_IN;
        sel = head[grant];
    end

    // Next-state for the registered completion port and round-robin pointer
    always_comb begin
        new_exec_d = 1'b0;
        alt_req_d  = 1'b0;
        exec_pos_d = exec_pos_q;
        alt_pos_d  = alt_pos_q;
        alt_pc_d   = alt_pc_q;
        rr_ptr_d   = rr_ptr_q;
        if (!FLUSH_IN && found) begin
            new_exec_d = 1'b1;
            exec_pos_d = sel.pos;
            alt_pos_d  = sel.pos;
            alt_req_d  = sel.altpc_valid;
            alt_pc_d   = sel.altpc_valid ? sel.altpc : 32'h0;
            rr_ptr_d   = (grant == RR_W'(NUM_REQ - 1)) ? '0 : grant + RR_W'(1);
        end
    end

    // Output and pointer registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            new_exec_q <= 1'b0;
            exec_pos_q <= '0;
            alt_req_q  <= 1'b0;
            alt_pos_q  <= '0;
            alt_pc_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            new_exec_q <= new_exec_d;
            exec_pos_q <= exec_pos_d;
            alt_req_q  <= alt_req_d;
            alt_pos_q  <= alt_pos_d;
            alt_pc_q   <= alt_pc_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign bus.newExecuted        = new_exec_q;
    assign bus.executedPosition   = exec_pos_q;
    assign bus.Request_Alt_PC_OUT = alt_req_q;
    assign bus.Alt_PC_position    = alt_pos_q;
    assign bus.Alt_PC_OUT         = alt_pc_q;

endmodule

// File: tb/tb_rob_completion_arbiter.sv
// Directed bench for rob_completion_arbiter with hand-computed expectations.
module tb_rob_completion_arbiter;

    logic CLK;
    logic RESET;
    logic FLUSH_IN;
    int   checks;
    int   failures;

    rob_completion_arbiter_if #(.NUM_REQ(4)) bus ();

    rob_completion_arbiter #(
        .NUM_REQ (4),
        .DEPTH   (2)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FLUSH_IN (FLUSH_IN),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [5:0] p,
                           input logic av, input logic [31:0] a);
        bus.req_valid[i]          = v;
        bus.req_pos[i*6 +: 6]     = p;
        bus.req_altpc_valid[i]    = av;
        bus.req_altpc[i*32 +: 32] = a;
    endtask

    task automatic clear_reqs();
        bus.req_valid       = '0;
        bus.req_pos         = '0;
        bus.req_altpc_valid = '0;
        bus.req_altpc       = '0;
    endtask

    task automatic reset_dut();
        RESET    = 1'b1;
        FLUSH_IN = 1'b0;
        clear_reqs();
        tick();
        tick();
        RESET = 1'b0;
    endtask

    logic [5:0] t3_tail [6];

    initial begin
        CLK      = 1'b0;
        checks   = 0;
        failures = 0;
        t3_tail  = '{6'd41, 6'd11, 6'd22, 6'd32, 6'd42, 6'd12};

        // Reset state
        RESET    = 1'b1;
        FLUSH_IN = 1'b0;
        clear_reqs();
        tick();
        chk("rst_ne", bus.newExecuted, 0);
        chk("rst_pos", bus.executedPosition, 0);
        chk("rst_altreq", bus.Request_Alt_PC_OUT, 0);
        chk("rst_altpos", bus.Alt_PC_position, 0);
        chk("rst_altpc", bus.Alt_PC_OUT, 0);
        chk("rst_ready", bus.req_ready, 4'h0);
        chk("rst_busy", bus.arb_busy, 0);
        chk("rst_rr", dut.rr_ptr_q, 0);
        RESET = 1'b0;
        #1;
        chk("post_rst_ready", bus.req_ready, 4'hF);

        // 1. Single request, two-cycle latency, one-cycle strobe
        set_req(2, 1'b1, 6'd17, 1'b0, 32'h0);
        tick();
        chk("t1_lat1_ne", bus.newExecuted, 0);
        chk("t1_busy", bus.arb_busy, 1);
        clear_reqs();
        tick();
        chk("t1_ne", bus.newExecuted, 1);
        chk("t1_pos", bus.executedPosition, 17);
        chk("t1_altreq", bus.Request_Alt_PC_OUT, 0);
        tick();
        chk("t1_ne_off", bus.newExecuted, 0);
        chk("t1_pos_hold", bus.executedPosition, 17);

        // 2. Four simultaneous pushes drain in index order from rr_ptr=0
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i + 1), 1'b0, 32'h0);
        tick();
        clear_reqs();
        chk("t2_busy0", bus.arb_busy, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_ne", bus.newExecuted, 1);
            chk("t2_pos", bus.executedPosition, 64'(i + 1));
            chk("t2_busy", bus.arb_busy, (i == 3) ? 64'd0 : 64'd1);
        end
        tick();
        chk("t2_ne_end", bus.newExecuted, 0);

        // 3. Backpressure on requester 0 with the others backlogged
        reset_dut();
        set_req(1, 1'b1, 6'd20, 1'b0, 32'h0);
        set_req(2, 1'b1, 6'd30, 1'b0, 32'h0);
        set_req(3, 1'b1, 6'd40, 1'b0, 32'h0);
        tick();
        chk("t3_e1_ne", bus.newExecuted, 0);
        set_req(0, 1'b1, 6'd10, 1'b0, 32'h0);
        set_req(1, 1'b1, 6'd21, 1'b0, 32'h0);
        set_req(2, 1'b1, 6'd31, 1'b0, 32'h0);
        set_req(3, 1'b1, 6'd41, 1'b0, 32'h0);
        tick();
        chk("t3_pos20", bus.executedPosition, 20);
        set_req(0, 1'b1, 6'd11, 1'b0, 32'h0);
        set_req(1, 1'b1, 6'd22, 1'b0, 32'h0);
        set_req(2, 1'b1, 6'd32, 1'b0, 32'h0);
        set_req(3, 1'b1, 6'd42, 1'b0, 32'h0);
        #1;
        chk("t3_ready_e3", bus.req_ready, 4'b0011);
        tick();
        chk("t3_pos30", bus.executedPosition, 30);
        set_req(0, 1'b1, 6'd12, 1'b0, 32'h0);
        set_req(1, 1'b0, 6'd0, 1'b0, 32'h0);
        #1;
        chk("t3_ready0_third", bus.req_ready, 4'b0100);
        tick();
        chk("t3_pos40", bus.executedPosition, 40);
        set_req(2, 1'b0, 6'd0, 1'b0, 32'h0);
        #1;
        chk("t3_ready_e5", bus.req_ready, 4'b1000);
        tick();
        chk("t3_pos10", bus.executedPosition, 10);
        set_req(3, 1'b0, 6'd0, 1'b0, 32'h0);
        #1;
        chk("t3_ready_e6", bus.req_ready, 4'b0001);
        tick();
        chk("t3_pos21", bus.executedPosition, 21);
        clear_reqs();
        tick();
        chk("t3_pos31", bus.executedPosition, 31);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_tail_ne", bus.newExecuted, 1);
            chk("t3_tail_pos", bus.executedPosition, t3_tail[i]);
        end
        chk("t3_busy_end", bus.arb_busy, 0);
        tick();
        chk("t3_ne_end", bus.newExecuted, 0);

        // 4. Redirect fields travel with the completion
        reset_dut();
        set_req(1, 1'b1, 6'd63, 1'b1, 32'h0040_0100);
        set_req(2, 1'b1, 6'd5, 1'b0, 32'hDEAD_BEEF);
        tick();
        clear_reqs();
        tick();
        chk("t4_ne", bus.newExecuted, 1);
        chk("t4_pos", bus.executedPosition, 63);
        chk("t4_altreq", bus.Request_Alt_PC_OUT, 1);
        chk("t4_altpos", bus.Alt_PC_position, 63);
        chk("t4_altpc", bus.Alt_PC_OUT, 32'h0040_0100);
        tick();
        chk("t4b_pos", bus.Alt_PC_position, 5);
        chk("t4b_altreq", bus.Request_Alt_PC_OUT, 0);
        chk("t4b_altpc_zero", bus.Alt_PC_OUT, 0);

        // 5. Flush with five buffered entries and a coincident push
        reset_dut();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 6'(i + 1), 1'b0, 32'h0);
        tick();
        clear_reqs();
        set_req(0, 1'b1, 6'd5, 1'b0, 32'h0);
        set_req(1, 1'b1, 6'd6, 1'b0, 32'h0);
        tick();
        chk("t5_pre_pos", bus.executedPosition, 1);
        clear_reqs();
        FLUSH_IN = 1'b1;
        set_req(3, 1'b1, 6'd50, 1'b0, 32'h0);
        #1;
        chk("t5_ready_flush", bus.req_ready, 4'h0);
        tick();
        FLUSH_IN = 1'b0;
        clear_reqs();
        chk("t5_ne", bus.newExecuted, 0);
        chk("t5_altreq", bus.Request_Alt_PC_OUT, 0);
        chk("t5_busy", bus.arb_busy, 0);
        chk("t5_pos_hold", bus.executedPosition, 1);
        chk("t5_rr_hold", dut.rr_ptr_q, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_idle_ne", bus.newExecuted, 0);
        end
        set_req(2, 1'b1, 6'd9, 1'b0, 32'h0);
        tick();
        clear_reqs();
        tick();
        chk("t5_new_ne", bus.newExecuted, 1);
        chk("t5_new_pos", bus.executedPosition, 9);

        // 6. Reset with three entries buffered
        reset_dut();
        set_req(0, 1'b1, 6'd11, 1'b1, 32'h0000_1234);
        set_req(1, 1'b1, 6'd12, 1'b0, 32'h0);
        set_req(2, 1'b1, 6'd13, 1'b0, 32'h0);
        set_req(3, 1'b1, 6'd14, 1'b0, 32'h0);
        tick();
        clear_reqs();
        tick();
        chk("t6_pre_pos", bus.executedPosition, 11);
        chk("t6_pre_altpc", bus.Alt_PC_OUT, 32'h0000_1234);
        RESET = 1'b1;
        #1;
        chk("t6_ready_rst", bus.req_ready, 4'h0);
        chk("t6_busy_rst", bus.arb_busy, 0);
        tick();
        RESET = 1'b0;
        chk("t6_ne", bus.newExecuted, 0);
        chk("t6_pos", bus.executedPosition, 0);
        chk("t6_altreq", bus.Request_Alt_PC_OUT, 0);
        chk("t6_altpos", bus.Alt_PC_position, 0);
        chk("t6_altpc", bus.Alt_PC_OUT, 0);
        chk("t6_rr", dut.rr_ptr_q, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_idle_ne", bus.newExecuted, 0);
            chk("t6_idle_busy", bus.arb_busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
